// File: rtl/control_sequencer.sv
// Microstep counter and microcode decoder for the 8-bit computer.
// Produces the 16-bit control word from the current step, opcode and ALU flags.
module control_sequencer #(
  parameter int NUM_STEPS = 5,
  parameter bit EARLY_END = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        carry_flag,
  input  logic        zero_flag,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  localparam logic [2:0]  LAST_STEP = 3'(NUM_STEPS - 1);
  localparam logic [3:0]  OP_HLT    = 4'hF;
  localparam logic [15:0] CW_HLT    = 16'h8000;

  logic [2:0] r_step;
  logic       r_halted;
  logic [2:0] w_step_inc;
  logic [2:0] w_step_nxt;
  logic       w_halted_nxt;

  function automatic logic [15:0] decode(input logic [2:0] s, input logic [3:0] op,
                                         input logic c, input logic z);
    logic [15:0] w;
    w = 16'h0000;
    case (s)
      3'd0: w = 16'h4004;
      3'd1: w = 16'h1408;
      3'd2: begin
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4: w = 16'h4800;
          4'h5:    w = 16'h0A00;
          4'h6:    w = 16'h0802;
          4'h7:    w = c ? 16'h0802 : 16'h0000;
          4'h8:    w = z ? 16'h0802 : 16'h0000;
          4'hE:    w = 16'h0110;
          4'hF:    w = CW_HLT;
          default: w = 16'h0000;
        endcase
      end
      3'd3: begin
        case (op)
          4'h1:       w = 16'h1200;
          4'h2, 4'h3: w = 16'h1020;
          4'h4:       w = 16'h2100;
          default:    w = 16'h0000;
        endcase
      end
      3'd4: begin
        case (op)
          4'h2:    w = 16'h0281;
          4'h3:    w = 16'h02C1;
          default: w = 16'h0000;
        endcase
      end
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step   <= 3'd0;
      r_halted <= 1'b0;
    end else begin
      r_step   <= w_step_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // HLT freezes the counter at T2; steps 0 and 1 never end early since opcode is stale.
  always_comb begin
    w_step_inc   = r_step + 3'd1;
    w_step_nxt   = w_step_inc;
    w_halted_nxt = r_halted;
    if (r_halted) begin
      w_step_nxt = r_step;
    end else if (r_step == 3'd2 && opcode == OP_HLT) begin
      w_step_nxt   = r_step;
      w_halted_nxt = 1'b1;
    end else if (r_step == LAST_STEP) begin
      w_step_nxt = 3'd0;
    end else if (EARLY_END && r_step >= 3'd2 &&
                 decode(w_step_inc, opcode, carry_flag, zero_flag) == 16'h0000) begin
      w_step_nxt = 3'd0;
    end
  end

  always_comb begin
    ctrl = 16'h0000;
    if (!rst_n)
      ctrl = 16'h0000;
    else if (r_halted)
      ctrl = CW_HLT;
    else
      ctrl = decode(r_step, opcode, carry_flag, zero_flag);
  end

  assign step   = r_step;
  assign halted = r_halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: one instance with EARLY_END=1, one with EARLY_END=0.
// Expected per-cycle (step, ctrl, halted) come from an instruction-level model.
module tb_control_sequencer;

  localparam int NSTEPS = 5;

  typedef logic [15:0] wq_t[$];
  typedef struct {
    int step;
    int ctrl;
    int halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  op_e, op_n;
  logic        c_e, z_e, c_n, z_n;
  logic [15:0] ctrl_e, ctrl_n;
  logic [2:0]  step_e, step_n;
  logic        halted_e, halted_n;

  exp_t q_e[$];
  exp_t q_n[$];
  bit   mon_e = 1'b0;
  bit   mon_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  control_sequencer #(.NUM_STEPS(NSTEPS), .EARLY_END(1'b1)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .opcode(op_e), .carry_flag(c_e), .zero_flag(z_e),
    .ctrl(ctrl_e), .step(step_e), .halted(halted_e)
  );

  control_sequencer #(.NUM_STEPS(NSTEPS), .EARLY_END(1'b0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .opcode(op_n), .carry_flag(c_n), .zero_flag(z_n),
    .ctrl(ctrl_n), .step(step_n), .halted(halted_n)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Execute-phase control words of one instruction, in step order from T2.
  function automatic wq_t exec_list(input logic [3:0] op, input logic c, input logic z);
    wq_t q;
    q = {};
    case (op)
      4'h1: begin q.push_back(16'h4800); q.push_back(16'h1200); end
      4'h2: begin q.push_back(16'h4800); q.push_back(16'h1020); q.push_back(16'h0281); end
      4'h3: begin q.push_back(16'h4800); q.push_back(16'h1020); q.push_back(16'h02C1); end
      4'h4: begin q.push_back(16'h4800); q.push_back(16'h2100); end
      4'h5: q.push_back(16'h0A00);
      4'h6: q.push_back(16'h0802);
      4'h7: if (c) q.push_back(16'h0802);
      4'h8: if (z) q.push_back(16'h0802);
      4'hE: q.push_back(16'h0110);
      4'hF: q.push_back(16'h8000);
      default: ;
    endcase
    return q;
  endfunction

  task automatic drive(input bit sel, input logic [3:0] op, input logic c, input logic z);
    if (sel) begin op_n = op; c_n = c; z_n = z; end
    else     begin op_e = op; c_e = c; z_e = z; end
  endtask

  task automatic push(input bit sel, input int s, input int w, input int h);
    exp_t x;
    x.step = s; x.ctrl = w; x.halted = h;
    if (sel) q_n.push_back(x);
    else     q_e.push_back(x);
  endtask

  // Runs one instruction; stop_at >= 0 abandons it after that step.
  task automatic run_instr(input bit sel, input logic [3:0] op, input logic c, input logic z,
                           input bit skip_first, input int stop_at);
    wq_t ex;
    int  len;
    int  w;
    ex = exec_list(op, c, z);
    if (op == 4'hF)       len = 3;
    else if (sel == 1'b0) len = 2 + ((ex.size() > 0) ? ex.size() : 1);
    else                  len = NSTEPS;
    for (int k = 0; k < len; k++) begin
      if (!(k == 0 && skip_first)) begin
        @(posedge clk);
        #1;
      end
      if (k < 2) drive(sel, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      else       drive(sel, op, c, z);
      if (k == 0)                w = 16'h4004;
      else if (k == 1)           w = 16'h1408;
      else if (k - 2 < ex.size()) w = int'(ex[k-2]);
      else                       w = 0;
      push(sel, k, w, 0);
      if (k == stop_at) return;
    end
    if (op == 4'hF) begin
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        #1;
        drive(sel, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        push(sel, 2, 16'h8000, 1);
      end
    end
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_step_e"}, int'(step_e), 0);
    chk({tag, "_ctrl_e"}, int'(ctrl_e), 0);
    chk({tag, "_halt_e"}, int'(halted_e), 0);
    chk({tag, "_step_n"}, int'(step_n), 0);
    chk({tag, "_ctrl_n"}, int'(ctrl_n), 0);
    chk({tag, "_halt_n"}, int'(halted_n), 0);
    q_e.delete();
    q_n.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk({tag, "_rel_ctrl_e"}, int'(ctrl_e), 16'h4004);
    chk({tag, "_rel_step_e"}, int'(step_e), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (rst_n && mon_e) begin
      if (q_e.size() == 0) chk("e_queue_empty", 1, 0);
      else begin
        x = q_e.pop_front();
        chk("e_step", int'(step_e), x.step);
        chk("e_ctrl", int'(ctrl_e), x.ctrl);
        chk("e_halted", int'(halted_e), x.halted);
      end
    end
    if (rst_n && mon_n) begin
      if (q_n.size() == 0) chk("n_queue_empty", 1, 0);
      else begin
        x = q_n.pop_front();
        chk("n_step", int'(step_n), x.step);
        chk("n_ctrl", int'(ctrl_n), x.ctrl);
        chk("n_halted", int'(halted_n), x.halted);
      end
    end
  end

  logic [3:0] dir_op [14] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h7,
                              4'h8, 4'h8, 4'hE, 4'h0, 4'h9, 4'hD};
  logic       dir_f  [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b1;
    op_e = 4'h0; c_e = 1'b0; z_e = 1'b0;
    op_n = 4'h0; c_n = 1'b0; z_n = 1'b0;
    #1;
    rst_n = 1'b0;
    #2;
    chk("rst_step", int'(step_e), 0);
    chk("rst_ctrl", int'(ctrl_e), 0);
    chk("rst_halted", int'(halted_e), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_e = 1'b1;

    run_instr(1'b0, dir_op[0], dir_f[0], dir_f[0], 1'b1, -1);
    for (int i = 1; i < 14; i++)
      run_instr(1'b0, dir_op[i], dir_f[i], dir_f[i], 1'b0, -1);

    run_instr(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 3);
    reset_pulse("midadd");
    run_instr(1'b0, 4'h3, 1'b1, 1'b0, 1'b1, -1);

    for (int i = 0; i < 40; i++)
      run_instr(1'b0, 4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), 1'b0, -1);

    run_instr(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, -1);
    mon_e = 1'b0;
    reset_pulse("halt_e");

    mon_n = 1'b1;
    run_instr(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, -1);
    run_instr(1'b1, 4'h7, 1'b1, 1'b0, 1'b0, -1);
    run_instr(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, -1);
    run_instr(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 25; i++)
      run_instr(1'b1, 4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), 1'b0, -1);
    run_instr(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);
    #1;
    mon_n = 1'b0;
    reset_pulse("halt_n");

    chk("e_queue_drained", q_e.size(), 0);
    chk("n_queue_drained", q_n.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
